// File: rtl/led_ctrl_wb.sv
// Wishbone LED controller: per-channel direct/blink/PWM modes on a shared prescaler tick,
// with atomic set/clear/toggle of the channel enable register.
module led_ctrl_wb #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_LEDS     = 7,
    parameter int PWM_BITS     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic                    wb_we_i,
    input  logic [SELECT_WIDTH-1:0] wb_sel_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rty_o,
    output logic [NUM_LEDS-1:0]     led_o
);
    localparam int IDX_W = 5;

    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NUM_LEDS-1:0]   out_q, out_d;
    logic [15:0]           presc_q, presc_d;
    logic [15:0]           presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [1:0]            mode_q [NUM_LEDS];
    logic [1:0]            mode_d [NUM_LEDS];
    logic [PWM_BITS-1:0]   duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0]   duty_d [NUM_LEDS];
    logic [15:0]           half_q [NUM_LEDS];
    logic [15:0]           half_d [NUM_LEDS];
    logic [15:0]           blink_cnt_q [NUM_LEDS];
    logic [15:0]           blink_cnt_d [NUM_LEDS];
    logic [NUM_LEDS-1:0]   phase_q, phase_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;

    logic [7:0]            adr;
    logic                  req, wr, tick;
    logic                  hit_out, hit_tog, hit_clr, hit_set, hit_presc, hit_cfg;
    logic [IDX_W-1:0]      cfg_idx;
    logic [DATA_WIDTH-1:0] byte_mask, wdat, rd_data;
    logic [NUM_LEDS-1:0]   cfg_wr, pwm_on;
    logic                  unused_adr;

    assign adr       = wb_adr_i[7:0];
    assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr        = req & wb_we_i;
    assign hit_out   = (adr == 8'h00);
    assign hit_tog   = (adr == 8'h04);
    assign hit_clr   = (adr == 8'h08);
    assign hit_set   = (adr == 8'h0C);
    assign hit_presc = (adr == 8'h10);
    assign hit_cfg   = adr[7] && (adr[1:0] == 2'b00);
    assign cfg_idx   = adr[6:2];
    assign tick      = (presc_cnt_q == presc_q);
    assign wdat      = wb_dat_i & byte_mask;
    assign unused_adr = ^wb_adr_i[ADDR_WIDTH-1:8];

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < SELECT_WIDTH; b++) begin
            byte_mask[8*b +: 8] = {8{wb_sel_i[b]}};
        end
    end

    // CFG slots beyond NUM_LEDS never match an index, so they read 0 and drop writes.
    always_comb begin
        rd_data = '0;
        cfg_wr  = '0;
        if (hit_out || hit_tog || hit_clr || hit_set) begin
            rd_data[NUM_LEDS-1:0] = out_q;
        end else if (hit_presc) begin
            rd_data[15:0] = presc_q;
        end else if (hit_cfg) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    rd_data[1:0]           = mode_q[i];
                    rd_data[8 +: PWM_BITS] = duty_q[i];
                    rd_data[31:16]         = half_q[i];
                    cfg_wr[i]              = wr;
                end
            end
        end
    end

    always_comb begin
        ack_d = req;
        dat_d = req ? rd_data : dat_q;

        out_d = out_q;
        if (wr) begin
            if (hit_out) begin
                out_d = (out_q & ~byte_mask[NUM_LEDS-1:0]) | wdat[NUM_LEDS-1:0];
            end else if (hit_tog) begin
                out_d = out_q ^ wdat[NUM_LEDS-1:0];
            end else if (hit_clr) begin
                out_d = out_q & ~wdat[NUM_LEDS-1:0];
            end else if (hit_set) begin
                out_d = out_q | wdat[NUM_LEDS-1:0];
            end
        end

        presc_d = presc_q;
        if (wr && hit_presc) begin
            presc_d = (presc_q & ~byte_mask[15:0]) | wdat[15:0];
        end
        presc_cnt_d = (tick || (wr && hit_presc)) ? 16'd0 : presc_cnt_q + 16'd1;
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    end

    always_comb begin
        phase_d = phase_q;
        led_d   = '0;
        pwm_on  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i]      = mode_q[i];
            duty_d[i]      = duty_q[i];
            half_d[i]      = half_q[i];
            blink_cnt_d[i] = blink_cnt_q[i];
            // A config write restarts the blink pattern even if it coincides with a tick.
            if (cfg_wr[i]) begin
                if (wb_sel_i[0]) mode_d[i] = wb_dat_i[1:0];
                if (wb_sel_i[1]) duty_d[i] = wb_dat_i[8 +: PWM_BITS];
                half_d[i]      = (half_q[i] & ~byte_mask[31:16]) | wdat[31:16];
                blink_cnt_d[i] = 16'd0;
                phase_d[i]     = 1'b0;
            end else if (tick) begin
                if (blink_cnt_q[i] >= ((half_q[i] <= 16'd1) ? 16'd0 : half_q[i] - 16'd1)) begin
                    blink_cnt_d[i] = 16'd0;
                    phase_d[i]     = ~phase_q[i];
                end else begin
                    blink_cnt_d[i] = blink_cnt_q[i] + 16'd1;
                end
            end
            pwm_on[i] = (pwm_cnt_q < duty_q[i]);
            led_d[i]  = out_q[i] & (~mode_q[i][0] | phase_q[i]) & (~mode_q[i][1] | pwm_on[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            out_q       <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            phase_q     <= '0;
            led_q       <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]      <= '0;
                duty_q[i]      <= '0;
                half_q[i]      <= '0;
                blink_cnt_q[i] <= '0;
            end
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            out_q       <= out_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]      <= mode_d[i];
                duty_q[i]      <= duty_d[i];
                half_q[i]      <= half_d[i];
                blink_cnt_q[i] <= blink_cnt_d[i];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign led_o    = led_q;

endmodule
